btn_debounce: RTL and testbench



---
 rtl/btn_debounce.sv | 133 +++++++++++++
 tb/tb_btn_debounce.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// btn_debounce: multi-channel switch/button conditioner.
// Each channel passes its raw level through a 2-FF synchronizer and then a
// counter-based debouncer. A new level is accepted only after the
// synchronized input has disagreed with the current output for
// DEBOUNCE_CYCLES consecutive clocks. The accepted level is driven on
// btn_out, and a one-cycle btn_rise/btn_fall pulse marks each change.
// Every output comes straight from a flop, so there is no combinational
// path from btn_in to any output.
//
// Per-channel state view (state_q), kept for checkers and debug:
//   ST_STABLE  : no mismatch is being timed (cnt == 0)
//   ST_PENDING : a mismatch is being timed (cnt != 0)
//
// DEBOUNCE_CYCLES must be at least 2.
module btn_debounce #(
   parameter int N_CH            = 2,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] btn_in,
   output logic [N_CH-1:0] btn_out,
   output logic [N_CH-1:0] btn_rise,
   output logic [N_CH-1:0] btn_fall
);

   // The counter has to hold values up to DEBOUNCE_CYCLES-1.
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {
      ST_STABLE  = 1'b0,
      ST_PENDING = 1'b1
   } state_e;

   // Synchronizer stages. btn_in is asynchronous, so only sync2_q feeds logic.
   logic [N_CH-1:0]            sync1_q, sync1_d;
   logic [N_CH-1:0]            sync2_q, sync2_d;

   // Debounce counters and registered outputs.
   logic [N_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [N_CH-1:0]            out_q, out_d;
   logic [N_CH-1:0]            rise_q, rise_d;
   logic [N_CH-1:0]            fall_q, fall_d;

   // State view for each channel.
   state_e                     state_q [N_CH];
   state_e                     state_d [N_CH];

   // Next-state logic for the synchronizer shift and per-channel debounce.
   always_comb begin
      sync1_d = btn_in;
      sync2_d = sync1_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      rise_d  = '0;
      fall_d  = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (sync2_q[i] == out_q[i]) begin
            // Input agrees with the accepted level. Any pending count is dropped.
            cnt_d[i] = '0;
         end else if (cnt_q[i] != CNT_MAX) begin
            // Input still disagrees. Keep timing the mismatch.
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end else begin
            // The mismatch has lasted long enough. Commit the new level and pulse once.
            out_d[i]  = sync2_q[i];
            cnt_d[i]  = '0;
            rise_d[i] = sync2_q[i];
            fall_d[i] = ~sync2_q[i];
         end
      end
   end

   // State view: a channel is pending while its counter is non-zero.
   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         state_d[i] = (cnt_d[i] != '0) ? ST_PENDING : ST_STABLE;
      end
   end

   // All state registers. Asynchronous reset clears everything, including pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         cnt_q   <= '0;
         out_q   <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
         for (int i = 0; i < N_CH; i++) begin
            state_q[i] <= ST_STABLE;
         end
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         for (int i = 0; i < N_CH; i++) begin
            state_q[i] <= state_d[i];
         end
      end
   end

   assign btn_out  = out_q;
   assign btn_rise = rise_q;
   assign btn_fall = fall_q;

`ifndef SYNTHESIS
   // Simulation-only invariants, one set per channel.
   for (genvar g = 0; g < N_CH; g++) begin : g_chk
      // A channel never pulses rise and fall together.
      a_no_both : assert property (@(posedge clk) disable iff (!rst_n)
         !(rise_q[g] && fall_q[g]))
         else $error("btn_debounce: rise and fall together on channel %0d", g);
      // A rise pulse coincides with btn_out high.
      a_rise_lvl : assert property (@(posedge clk) disable iff (!rst_n)
         rise_q[g] |-> out_q[g])
         else $error("btn_debounce: rise without high level on channel %0d", g);
      // A fall pulse coincides with btn_out low.
      a_fall_lvl : assert property (@(posedge clk) disable iff (!rst_n)
         fall_q[g] |-> !out_q[g])
         else $error("btn_debounce: fall without low level on channel %0d", g);
      // The state view agrees with the counter.
      a_state : assert property (@(posedge clk) disable iff (!rst_n)
         (state_q[g] == ST_STABLE) == (cnt_q[g] == '0))
         else $error("btn_debounce: state view out of step on channel %0d", g);
   end
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce with N_CH=2 and DEBOUNCE_CYCLES=4.
// The reference model sees the synchronizer as a two-sample delay line. A
// channel takes a new level once the last DEBOUNCE_CYCLES delayed samples
// all differ from the current level. A checker compares the DUT with this
// model on every falling clock edge. Directed sections add literal,
// hand-timed expectations, and a randomized section follows them.
module tb_btn_debounce;

   localparam int N_CH = 2;
   localparam int DC   = 4;

   logic            clk;
   logic            rst_n;
   logic [N_CH-1:0] btn_in;
   logic [N_CH-1:0] btn_out;
   logic [N_CH-1:0] btn_rise;
   logic [N_CH-1:0] btn_fall;

   int checks = 0;
   int errors = 0;

   btn_debounce #(
      .N_CH            (N_CH),
      .DEBOUNCE_CYCLES (DC)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_in   (btn_in),
      .btn_out  (btn_out),
      .btn_rise (btn_rise),
      .btn_fall (btn_fall)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [N_CH-1:0] raw_h [$];   // btn_in samples still inside the 2-stage delay
   logic [N_CH-1:0] s2_h  [$];   // the last DC synchronized samples seen at edges
   logic [N_CH-1:0] m_out, m_rise, m_fall;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         raw_h.delete();
         raw_h.push_back('0);
         raw_h.push_back('0);
         s2_h.delete();
         m_out  = '0;
         m_rise = '0;
         m_fall = '0;
      end else begin
         logic [N_CH-1:0] s2_now;
         s2_now = raw_h[0];
         s2_h.push_back(s2_now);
         if (s2_h.size() > DC) void'(s2_h.pop_front());
         m_rise = '0;
         m_fall = '0;
         for (int c = 0; c < N_CH; c++) begin
            bit all_diff;
            all_diff = (s2_h.size() == DC);
            foreach (s2_h[k]) if (s2_h[k][c] == m_out[c]) all_diff = 1'b0;
            if (all_diff) begin
               m_out[c]  = s2_now[c];
               m_rise[c] = s2_now[c];
               m_fall[c] = ~s2_now[c];
            end
         end
         raw_h.push_back(btn_in);
         void'(raw_h.pop_front());
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      checks++;
      if (btn_out !== m_out) begin
         errors++;
         $display("FAIL model_out t=%0t: got %b expected %b", $time, btn_out, m_out);
      end
      checks++;
      if (btn_rise !== m_rise) begin
         errors++;
         $display("FAIL model_rise t=%0t: got %b expected %b", $time, btn_rise, m_rise);
      end
      checks++;
      if (btn_fall !== m_fall) begin
         errors++;
         $display("FAIL model_fall t=%0t: got %b expected %b", $time, btn_fall, m_fall);
      end
   end

   // ---------------- driver helpers ----------------
   // Wait n rising edges, then settle 2 time units past the edge.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic chk(input string name, input logic [N_CH-1:0] got,
                      input logic [N_CH-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s t=%0t: got %b expected %b", name, $time, got, exp);
      end
   endtask

   // ---------------- directed then random stimulus ----------------
   initial begin
      rst_n  = 1'b0;
      btn_in = 2'b11;

      // Reset held for 10 cycles with both inputs high: outputs stay 0.
      for (int k = 0; k < 10; k++) begin
         tick(1);
         chk("rst_out", btn_out, 2'b00);
         chk("rst_pulse", btn_rise | btn_fall, 2'b00);
      end
      rst_n = 1'b1;
      tick(5);
      chk("rel_out_e4", btn_out, 2'b00);
      tick(1);
      chk("rel_out_e5", btn_out, 2'b11);
      chk("rel_rise_e5", btn_rise, 2'b11);
      tick(1);
      chk("rel_rise_e6", btn_rise, 2'b00);

      // Release both channels: they fall together after 6 edges.
      btn_in = 2'b00;
      tick(6);
      chk("both_fall", btn_fall, 2'b11);
      chk("both_fall_out", btn_out, 2'b00);
      tick(2);

      // Clean press and release on channel 0.
      btn_in = 2'b01;
      tick(5);
      chk("press_e4", btn_out, 2'b00);
      tick(1);
      chk("press_e5", btn_out, 2'b01);
      chk("press_rise", btn_rise, 2'b01);
      tick(1);
      chk("press_rise_gone", btn_rise, 2'b00);
      btn_in = 2'b00;
      tick(5);
      chk("release_e4", btn_out, 2'b01);
      tick(1);
      chk("release_e5", btn_out, 2'b00);
      chk("release_fall", btn_fall, 2'b01);
      tick(1);
      chk("release_fall_gone", btn_fall, 2'b00);
      tick(2);

      // Bounce on channel 0: alternate 1,0 for 8 cycles, then hold 1.
      for (int k = 0; k < 8; k++) begin
         btn_in = (k % 2 == 0) ? 2'b01 : 2'b00;
         tick(1);
         chk("bounce_out", btn_out, 2'b00);
      end
      btn_in = 2'b01;
      tick(5);
      chk("bounce_hold_e4", btn_out, 2'b00);
      tick(1);
      chk("bounce_hold_e5", btn_out, 2'b01);
      chk("bounce_rise", btn_rise, 2'b01);
      btn_in = 2'b00;
      tick(8);
      chk("bounce_back_low", btn_out, 2'b00);

      // Glitch on channel 1: 3 cycles high is too short to be accepted.
      btn_in = 2'b10;
      tick(3);
      btn_in = 2'b00;
      for (int k = 0; k < 8; k++) begin
         tick(1);
         chk("glitch_out", btn_out, 2'b00);
         chk("glitch_pulse", btn_rise | btn_fall, 2'b00);
      end

      // Simultaneous press on both channels, then staggered releases.
      btn_in = 2'b11;
      tick(6);
      chk("simul_out", btn_out, 2'b11);
      chk("simul_rise", btn_rise, 2'b11);
      btn_in = 2'b10;
      tick(2);
      btn_in = 2'b00;
      tick(4);
      chk("stag_fall0", btn_fall, 2'b01);
      chk("stag_out0", btn_out, 2'b10);
      tick(2);
      chk("stag_fall1", btn_fall, 2'b10);
      chk("stag_out1", btn_out, 2'b00);
      tick(2);

      // Asynchronous reset two cycles into a release count.
      btn_in = 2'b01;
      tick(8);
      chk("mid_pre_out", btn_out, 2'b01);
      btn_in = 2'b00;
      tick(4);
      #1 rst_n = 1'b0;
      #1;
      chk("async_out", btn_out, 2'b00);
      chk("async_pulse", btn_rise | btn_fall, 2'b00);
      tick(3);
      rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick(1);
         chk("post_rst_quiet", btn_out | btn_rise | btn_fall, 2'b00);
      end

      // Randomized holds, with occasional asynchronous resets.
      for (int it = 0; it < 300; it++) begin
         btn_in = N_CH'($urandom_range(0, (1 << N_CH) - 1));
         tick($urandom_range(1, 8));
         if ($urandom_range(0, 39) == 0) begin
            #($urandom_range(0, 4)) rst_n = 1'b0;
            tick($urandom_range(1, 3));
            rst_n = 1'b1;
         end
      end
      tick(10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
